// File: rtl/uart_pkg.sv
// Shared types, defaults and elaboration helpers for the UART receive path.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int DEF_CLK_FREQ  = 50_000_000;
  localparam int DEF_BAUD      = 115200;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_IDLE_BITS = 20;

  // Rounded clocks-per-sample divider.
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider; restart realigns the phase to a detected start edge.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (restart || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronised, oversampled, majority-voted bit recovery
// with framing-error, break handling and post-byte idle timeout.
`timescale 1ns/1ps
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int IDLE_BITS  = DEF_IDLE_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       rok,
  output logic [7:0] mosi,
  output logic       frame_err,
  output logic       busy,
  output logic       idle_to
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int ICW = $clog2(IDLE_BITS + 1);
  localparam logic [SCW-1:0] SC_A    = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_B    = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] SC_C    = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_BITS - 1);

  rx_state_t state, state_nxt;
  logic       rxd_m, rxd_s, rxd_d;
  logic       start_edge, tick, vote_tick, bit_end, vote;
  logic       samp_a, samp_b;
  logic [SCW-1:0] sc;
  logic [2:0] bit_idx, bit_idx_nxt;
  logic [7:0] shreg, shreg_nxt, mosi_nxt;
  logic       rok_nxt, ferr_nxt, armed;
  logic [ICW-1:0] idle_cnt;

  // rxd_d is the previous synchronised value, used only for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign start_edge = (state == IDLE) && rxd_d && !rxd_s;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (start_edge),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc     <= '0;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (start_edge) begin
      sc <= '0;
    end else if (tick) begin
      sc <= (sc == SC_LAST) ? '0 : sc + SCW'(1);
      if (sc == SC_A) samp_a <= rxd_s;
      if (sc == SC_B) samp_b <= rxd_s;
    end
  end

  // Third sample is taken live on the vote tick.
  assign vote_tick = tick && (sc == SC_C);
  assign bit_end   = tick && (sc == SC_LAST);
  assign vote      = (samp_a & samp_b) | (samp_a & rxd_s) | (samp_b & rxd_s);

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    mosi_nxt    = mosi;
    rok_nxt     = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      IDLE:  if (start_edge) state_nxt = START;
      START: if (vote_tick) begin
               if (!vote) begin
                 state_nxt   = DATA;
                 bit_idx_nxt = 3'd0;
               end else begin
                 state_nxt = IDLE;
               end
             end
      DATA:  if (vote_tick) begin
               shreg_nxt   = {vote, shreg[7:1]};
               bit_idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nxt = STOP;
             end
      STOP:  if (vote_tick) begin
               if (vote) begin
                 mosi_nxt  = shreg;
                 rok_nxt   = 1'b1;
                 state_nxt = IDLE;
               end else begin
                 ferr_nxt  = 1'b1;
                 state_nxt = BREAK;
               end
             end
      BREAK: if (rxd_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      mosi      <= '0;
      rok       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      mosi      <= mosi_nxt;
      rok       <= rok_nxt;
      frame_err <= ferr_nxt;
    end
  end

  assign busy = (state != IDLE);

  // Armed only after a byte or framing error, so reset alone never times out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      armed    <= 1'b0;
      idle_to  <= 1'b0;
    end else begin
      idle_to <= 1'b0;
      if (rok || frame_err) begin
        idle_cnt <= '0;
        armed    <= 1'b1;
      end else if (busy) begin
        idle_cnt <= '0;
      end else if (armed && bit_end) begin
        if (idle_cnt == IDLE_LAST) begin
          idle_to  <= 1'b1;
          armed    <= 1'b0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + ICW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: 64-clock bit time (DIV=4), async serial drive.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam real CLK_NS = 10.0;
  localparam real BIT_NS = 640.0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rok, frame_err, busy, idle_to;
  logic [7:0] mosi;

  int vectors = 0;
  int miscompares = 0;
  int rok_cnt = 0, ferr_cnt = 0, ito_cnt = 0;
  int rok_busy = 0, excl_err = 0, width_err = 0;
  logic rok_prev = 1'b0;
  logic [7:0] rx_q[$];

  uart_rx_byte #(
    .CLK_FREQ   (7_372_800),
    .BAUD       (115200),
    .OVERSAMPLE (16),
    .IDLE_BITS  (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rok       (rok),
    .mosi      (mosi),
    .frame_err (frame_err),
    .busy      (busy),
    .idle_to   (idle_to)
  );

  always #(CLK_NS / 2.0) clk = ~clk;

  always @(negedge clk) begin
    if (rok) begin
      rok_cnt++;
      rx_q.push_back(mosi);
      if (busy) rok_busy++;
    end
    if (frame_err) ferr_cnt++;
    if (idle_to) ito_cnt++;
    if (rok && frame_err) excl_err++;
    if (rok && rok_prev) width_err++;
    rok_prev = rok;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] q_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  task automatic send(input logic [7:0] d, input real bit_ns, input logic stop_v);
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      #(bit_ns);
    end
    rxd = stop_v;
    #(bit_ns);
  endtask

  int r0, f0, i0;
  real rates[2];
  logic [7:0] pat[3];

  initial begin
    rates[0] = BIT_NS / 1.03;
    rates[1] = BIT_NS / 0.97;
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'hAA;

    // reset values
    repeat (5) @(negedge clk);
    chk("rst_rok", rok, 1'b0);
    chk("rst_mosi", mosi, 8'h00);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_idle_to", idle_to, 1'b0);
    rst_n = 1'b1;

    #(25 * BIT_NS);
    chk("no_idle_to_after_reset", ito_cnt, 0);

    // single byte 0xA5
    rx_q.delete(); r0 = rok_cnt; f0 = ferr_cnt;
    send(8'hA5, BIT_NS, 1'b1);
    #(2 * BIT_NS);
    chk("a5_rok_count", rok_cnt - r0, 1);
    chk("a5_mosi", q_at(0), 8'hA5);
    chk("a5_no_ferr", ferr_cnt - f0, 0);
    chk("a5_busy_low_at_rok", rok_busy, 0);

    // short glitch
    r0 = rok_cnt; f0 = ferr_cnt;
    rxd = 1'b0; #(3 * CLK_NS); rxd = 1'b1;
    #80;
    chk("glitch_busy_high", busy, 1'b1);
    #500;
    chk("glitch_busy_low", busy, 1'b0);
    chk("glitch_no_rok", rok_cnt - r0, 0);
    chk("glitch_no_ferr", ferr_cnt - f0, 0);

    // back-to-back bytes, then idle timeout
    rx_q.delete(); r0 = rok_cnt; i0 = ito_cnt;
    send(8'h00, BIT_NS, 1'b1);
    send(8'h05, BIT_NS, 1'b1);
    send(8'h03, BIT_NS, 1'b1);
    send(8'h12, BIT_NS, 1'b1);
    send(8'h34, BIT_NS, 1'b1);
    #(15 * BIT_NS);
    chk("b2b_rok_count", rok_cnt - r0, 5);
    chk("b2b_byte0", q_at(0), 8'h00);
    chk("b2b_byte1", q_at(1), 8'h05);
    chk("b2b_byte2", q_at(2), 8'h03);
    chk("b2b_byte3", q_at(3), 8'h12);
    chk("b2b_byte4", q_at(4), 8'h34);
    chk("idle_to_not_early", ito_cnt - i0, 0);
    #(10 * BIT_NS);
    chk("idle_to_once", ito_cnt - i0, 1);
    #(10 * BIT_NS);
    chk("idle_to_quiet", ito_cnt - i0, 1);

    // framing error then held-low line
    rx_q.delete(); r0 = rok_cnt; f0 = ferr_cnt;
    send(8'h3C, BIT_NS, 1'b0);
    #(30 * BIT_NS);
    chk("ferr_count", ferr_cnt - f0, 1);
    chk("ferr_no_rok", rok_cnt - r0, 0);
    chk("ferr_mosi_kept", mosi, 8'h34);
    chk("ferr_busy_in_break", busy, 1'b1);
    rxd = 1'b1;
    #(2 * BIT_NS);
    send(8'h55, BIT_NS, 1'b1);
    #(2 * BIT_NS);
    chk("after_break_rok", rok_cnt - r0, 1);
    chk("after_break_mosi", q_at(0), 8'h55);
    chk("after_break_ferr", ferr_cnt - f0, 1);

    // reset during bit 4 of 0xFF
    rxd = 1'b0; #(BIT_NS);
    rxd = 1'b1; #(4.5 * BIT_NS);
    rst_n = 1'b0;
    #40;
    @(negedge clk);
    chk("midrst_rok", rok, 1'b0);
    chk("midrst_mosi", mosi, 8'h00);
    chk("midrst_ferr", frame_err, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_idle_to", idle_to, 1'b0);
    rst_n = 1'b1;
    rx_q.delete(); r0 = rok_cnt;
    #(4 * BIT_NS);
    send(8'h81, BIT_NS, 1'b1);
    #(2 * BIT_NS);
    chk("postrst_rok", rok_cnt - r0, 1);
    chk("postrst_mosi", q_at(0), 8'h81);

    // +3% and -3% baud
    for (int r = 0; r < 2; r++) begin
      rx_q.delete(); r0 = rok_cnt; f0 = ferr_cnt;
      for (int b = 0; b < 3; b++) begin
        send(pat[b], rates[r], 1'b1);
        #(2 * BIT_NS);
      end
      chk($sformatf("skew%0d_rok", r), rok_cnt - r0, 3);
      for (int b = 0; b < 3; b++)
        chk($sformatf("skew%0d_byte%0d", r, b), q_at(b), pat[b]);
      chk($sformatf("skew%0d_no_ferr", r), ferr_cnt - f0, 0);
    end

    chk("rok_ferr_exclusive", excl_err, 0);
    chk("rok_single_cycle", width_err, 0);
    chk("rok_busy_overlap", rok_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
